// File: rtl/lifo_stack_if.sv
// Handshake/status bundle for lifo_stack: the master issues push/pop/clear
// requests, the slave (the stack) reports top-of-stack data and occupancy.
interface lifo_stack_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             push;
    logic             pop;
    logic             clear;
    logic             err_clr;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] top_data;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, clear, err_clr, data_in,
        input  top_data, count, empty, full, almost_full, overflow, underflow
    );

    modport slave (
        input  push, pop, clear, err_clr, data_in,
        output top_data, count, empty, full, almost_full, overflow, underflow
    );
endinterface

// File: rtl/lifo_stack.sv
// Register-array LIFO with zero-latency top-of-stack read, replace-top on
// simultaneous push+pop, and sticky overflow/underflow flags.
module lifo_stack #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input logic         clk,
    input logic         rst,
    lifo_stack_if.slave bus
);
    localparam int              CW        = $clog2(DEPTH + 1);
    localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0]   DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]   AF_CNT    = CW'(AF_LEVEL);

    typedef enum logic [1:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_REPLACE
    } op_e;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             overflow;
    logic             underflow;
    logic             ovf_set;
    logic             udf_set;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    top_addr;
    logic             is_empty;
    logic             is_full;
    op_e              op;

    assign is_empty = (count == '0);
    assign is_full  = (count == DEPTH_CNT);
    assign top_addr = AW'(count - CW'(1));

    // clear suppresses push/pop; push+pop on an empty stack degrades to a push.
    always_comb begin
        op = OP_NONE;
        if (!bus.clear) begin
            case ({bus.push, bus.pop})
                2'b10:   op = OP_PUSH;
                2'b01:   op = OP_POP;
                2'b11:   op = is_empty ? OP_PUSH : OP_REPLACE;
                default: op = OP_NONE;
            endcase
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        count_nxt = bus.clear ? '0 : count;
        wr_en     = 1'b0;
        wr_addr   = top_addr;
        ovf_set   = 1'b0;
        udf_set   = 1'b0;
        case (op)
            OP_PUSH: begin
                if (is_full) begin
                    ovf_set = 1'b1;
                end else begin
                    wr_en     = 1'b1;
                    wr_addr   = AW'(count);
                    count_nxt = count + CW'(1);
                end
            end
            OP_POP: begin
                if (is_empty) begin
                    udf_set = 1'b1;
                end else begin
                    count_nxt = count - CW'(1);
                end
            end
            OP_REPLACE: begin
                wr_en = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: storage is deliberately not reset; entries above count are never visible.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_addr] <= bus.data_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_nxt;
            overflow  <= ovf_set | (overflow & ~bus.err_clr);
            underflow <= udf_set | (underflow & ~bus.err_clr);
        end
    end

    assign bus.top_data    = is_empty ? '0 : mem[top_addr];
    assign bus.count       = count;
    assign bus.empty       = is_empty;
    assign bus.full        = is_full;
    assign bus.almost_full = (count >= AF_CNT);
    assign bus.overflow    = overflow;
    assign bus.underflow   = underflow;
endmodule

// File: tb/tb_lifo_stack.sv
// Directed self-checking bench for lifo_stack (WIDTH=8, DEPTH=4, AF_LEVEL=2).
module tb_lifo_stack;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    lifo_stack_if #(.WIDTH(8), .DEPTH(4)) bus ();

    lifo_stack #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.clear   = 1'b0;
        bus.err_clr = 1'b0;
        bus.data_in = 8'h00;
    endtask

    // Apply one cycle of stimulus at the falling edge; return 1ns after the rising edge.
    task automatic step(input logic p, input logic po, input logic c, input logic e,
                        input logic [7:0] d);
        @(negedge clk);
        bus.push    = p;
        bus.pop     = po;
        bus.clear   = c;
        bus.err_clr = e;
        bus.data_in = d;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst      = 1'b1;
        bus.push = 1'b1;
        bus.data_in = 8'hEE;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        n_cmp++; if ({bus.empty, bus.full, bus.almost_full} !== 3'b100) begin n_bad++; $display("FAIL reset_status: got e/f/af=%b expected 100", {bus.empty, bus.full, bus.almost_full}); end
        n_cmp++; if (bus.top_data !== 8'h00) begin n_bad++; $display("FAIL reset_top: got %h expected 00", bus.top_data); end
        n_cmp++; if ({bus.overflow, bus.underflow} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b expected 00", {bus.overflow, bus.underflow}); end
    endtask

    task automatic test_fill();
        step(1, 0, 0, 0, 8'h11);
        n_cmp++; if ({bus.count, bus.almost_full, bus.top_data} !== {3'd1, 1'b0, 8'h11}) begin n_bad++; $display("FAIL fill1: got cnt=%0d af=%b top=%h expected cnt=1 af=0 top=11", bus.count, bus.almost_full, bus.top_data); end
        step(1, 0, 0, 0, 8'h22);
        n_cmp++; if ({bus.count, bus.almost_full, bus.full} !== {3'd2, 1'b1, 1'b0}) begin n_bad++; $display("FAIL fill2: got cnt=%0d af=%b full=%b expected cnt=2 af=1 full=0", bus.count, bus.almost_full, bus.full); end
        step(1, 0, 0, 0, 8'h33);
        step(1, 0, 0, 0, 8'h44);
        n_cmp++; if ({bus.count, bus.full, bus.almost_full, bus.empty} !== {3'd4, 1'b1, 1'b1, 1'b0}) begin n_bad++; $display("FAIL fill4_status: got cnt=%0d f=%b af=%b e=%b expected cnt=4 f=1 af=1 e=0", bus.count, bus.full, bus.almost_full, bus.empty); end
        n_cmp++; if (bus.top_data !== 8'h44) begin n_bad++; $display("FAIL fill4_top: got %h expected 44", bus.top_data); end
    endtask

    task automatic test_overflow();
        step(1, 0, 0, 0, 8'h55);
        n_cmp++; if ({bus.overflow, bus.count, bus.top_data} !== {1'b1, 3'd4, 8'h44}) begin n_bad++; $display("FAIL ovf_set: got ovf=%b cnt=%0d top=%h expected ovf=1 cnt=4 top=44", bus.overflow, bus.count, bus.top_data); end
        step(0, 0, 0, 1, 8'h00);
        n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clr: got %b expected 0", bus.overflow); end
    endtask

    task automatic test_replace_full();
        logic [7:0] exp_seq [4];
        exp_seq = '{8'h99, 8'h33, 8'h22, 8'h11};
        step(1, 1, 0, 0, 8'h99);
        n_cmp++; if ({bus.count, bus.top_data, bus.overflow} !== {3'd4, 8'h99, 1'b0}) begin n_bad++; $display("FAIL replace_full: got cnt=%0d top=%h ovf=%b expected cnt=4 top=99 ovf=0", bus.count, bus.top_data, bus.overflow); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.pop = 1'b1;
            #1;
            n_cmp++; if (bus.top_data !== exp_seq[i]) begin n_bad++; $display("FAIL pop_seq%0d: got %h expected %h", i, bus.top_data, exp_seq[i]); end
            @(posedge clk);
            #1;
            idle_inputs();
        end
        n_cmp++; if ({bus.empty, bus.count, bus.top_data, bus.underflow} !== {1'b1, 3'd0, 8'h00, 1'b0}) begin n_bad++; $display("FAIL drained: got e=%b cnt=%0d top=%h udf=%b expected e=1 cnt=0 top=00 udf=0", bus.empty, bus.count, bus.top_data, bus.underflow); end
    endtask

    task automatic test_underflow();
        step(0, 1, 0, 1, 8'h00);
        n_cmp++; if ({bus.underflow, bus.count} !== {1'b1, 3'd0}) begin n_bad++; $display("FAIL udf_set_wins: got udf=%b cnt=%0d expected udf=1 cnt=0", bus.underflow, bus.count); end
        step(0, 0, 1, 0, 8'h00);
        n_cmp++; if (bus.underflow !== 1'b1) begin n_bad++; $display("FAIL clear_keeps_udf: got %b expected 1", bus.underflow); end
        step(0, 0, 0, 1, 8'h00);
        n_cmp++; if (bus.underflow !== 1'b0) begin n_bad++; $display("FAIL udf_clr: got %b expected 0", bus.underflow); end
    endtask

    task automatic test_replace_empty();
        step(1, 1, 0, 0, 8'hA5);
        n_cmp++; if ({bus.count, bus.top_data, bus.underflow} !== {3'd1, 8'hA5, 1'b0}) begin n_bad++; $display("FAIL pushpop_empty: got cnt=%0d top=%h udf=%b expected cnt=1 top=a5 udf=0", bus.count, bus.top_data, bus.underflow); end
        step(1, 0, 1, 0, 8'h77);
        n_cmp++; if ({bus.count, bus.empty, bus.top_data} !== {3'd0, 1'b1, 8'h00}) begin n_bad++; $display("FAIL clear_push: got cnt=%0d e=%b top=%h expected cnt=0 e=1 top=00", bus.count, bus.empty, bus.top_data); end
    endtask

    task automatic test_back_to_back();
        step(1, 0, 0, 0, 8'h01);
        step(1, 0, 0, 0, 8'h02);
        step(1, 1, 0, 0, 8'h0C);
        step(1, 0, 0, 0, 8'h03);
        n_cmp++; if ({bus.count, bus.top_data} !== {3'd3, 8'h03}) begin n_bad++; $display("FAIL b2b_push: got cnt=%0d top=%h expected cnt=3 top=03", bus.count, bus.top_data); end
        step(0, 1, 0, 0, 8'h00);
        n_cmp++; if ({bus.count, bus.top_data, bus.almost_full} !== {3'd2, 8'h0C, 1'b1}) begin n_bad++; $display("FAIL b2b_pop1: got cnt=%0d top=%h af=%b expected cnt=2 top=0c af=1", bus.count, bus.top_data, bus.almost_full); end
        step(0, 1, 0, 0, 8'h00);
        n_cmp++; if ({bus.count, bus.top_data, bus.almost_full} !== {3'd1, 8'h01, 1'b0}) begin n_bad++; $display("FAIL b2b_pop2: got cnt=%0d top=%h af=%b expected cnt=1 top=01 af=0", bus.count, bus.top_data, bus.almost_full); end
        step(0, 0, 1, 0, 8'h00);
    endtask

    task automatic test_reset_mid();
        step(1, 0, 0, 0, 8'hB1);
        step(1, 0, 0, 0, 8'hB2);
        step(1, 0, 0, 0, 8'hB3);
        step(1, 0, 0, 0, 8'hB4);
        step(1, 0, 0, 0, 8'hB5);
        step(0, 1, 0, 0, 8'h00);
        n_cmp++; if ({bus.count, bus.overflow, bus.top_data} !== {3'd3, 1'b1, 8'hB3}) begin n_bad++; $display("FAIL pre_rst: got cnt=%0d ovf=%b top=%h expected cnt=3 ovf=1 top=b3", bus.count, bus.overflow, bus.top_data); end
        @(negedge clk);
        rst         = 1'b1;
        bus.push    = 1'b1;
        bus.pop     = 1'b1;
        bus.data_in = 8'hCC;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        n_cmp++; if ({bus.count, bus.overflow, bus.empty, bus.top_data} !== {3'd0, 1'b0, 1'b1, 8'h00}) begin n_bad++; $display("FAIL mid_rst: got cnt=%0d ovf=%b e=%b top=%h expected cnt=0 ovf=0 e=1 top=00", bus.count, bus.overflow, bus.empty, bus.top_data); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        idle_inputs();
        test_reset();
        test_fill();
        test_overflow();
        test_replace_full();
        test_underflow();
        test_replace_empty();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lifo_stack.md
LIFO_STACK -- requirements
Module: lifo_stack

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data word width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning the number of entries (>=2, any integer, not only powers of two).
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, meaning the occupancy at or above which almost_full asserts (1..DEPTH).
REQ-004 The block SHALL define local CW = $clog2(DEPTH+1) as the width of the occupancy count.
REQ-005 clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous reset, active-high.
REQ-007 push  in  1  push request.
REQ-008 pop  in  1  pop request.
REQ-009 clear  in  1  synchronous flush of all entries.
REQ-010 err_clr  in  1  clears the sticky error flags.
REQ-011 data_in  in  WIDTH  word to push.
REQ-012 top_data  out  WIDTH  current top-of-stack word.
REQ-013 count  out  CW  number of valid entries, 0..DEPTH.
REQ-014 empty, full, almost_full  out  1 each  occupancy status.
REQ-015 overflow, underflow  out  1 each  sticky error flags.

Function
REQ-016 Per-cycle priority SHALL be rst > clear > push/pop; err_clr SHALL be evaluated independently of all three.
REQ-017 push=1, pop=0, count<DEPTH: mem[count] <= data_in, count <= count+1.
REQ-018 push=1, pop=0, count==DEPTH: no write, count unchanged, overflow <= 1.
REQ-019 pop=1, push=0, count>0: count <= count-1; the popped word is top_data in the same cycle pop is asserted (zero-latency read).
REQ-020 pop=1, push=0, count==0: count unchanged, underflow <= 1.
REQ-021 push=1, pop=1, count>0: replace top, i.e. mem[count-1] <= data_in, count unchanged; this SHALL hold when full (no overflow flag).
REQ-022 push=1, pop=1, count==0: behaves as a push (count becomes 1, mem[0] <= data_in), no underflow flag.
REQ-023 clear=1: count <= 0; push/pop ignored that cycle; overflow/underflow SHALL not be changed by clear.
REQ-024 err_clr=1 SHALL clear overflow and underflow, except that an error raised in the same cycle SHALL win (flag set).
REQ-025 top_data SHALL be combinational: mem[count-1] when count>0, else all zeros.
REQ-026 empty = (count==0), full = (count==DEPTH), almost_full = (count>=AF_LEVEL); all combinational from count.
REQ-027 count SHALL never exceed DEPTH nor go below 0; no pointer wrap-around is permitted.
REQ-028 Storage SHALL be a register array of DEPTH x WIDTH written only as in REQ-017/021/022.

Reset
REQ-029 On rst=1 at a rising edge: count <= 0, overflow <= 0, underflow <= 0; all other inputs ignored that cycle.
REQ-030 Post-reset outputs SHALL be: count=0, empty=1, full=0, almost_full=0 (AF_LEVEL>=1), top_data=0, overflow=0, underflow=0.
REQ-031 Storage contents SHALL not be reset; they are unobservable while count==0.
REQ-032 Reset asserted mid-sequence (e.g. during push+pop) SHALL discard the operation and yield the REQ-030 state next cycle.

Verification
REQ-033 WIDTH=8, DEPTH=4: push 0x11,0x22,0x33,0x44 -> count=4, full=1, almost_full=1 after 2nd push... (AF_LEVEL=2), top_data=0x44.
REQ-034 Full stack, push 0x55 -> overflow=1, count=4, top_data=0x44; then err_clr -> overflow=0.
REQ-035 Full stack, push+pop with 0x99 -> count=4, top_data=0x99, overflow=0; pop x4 -> top_data sequence 0x99,0x33,0x22,0x11, then empty=1, top_data=0x00.
REQ-036 Empty stack, pop -> underflow=1, count=0; same cycle err_clr=1 -> underflow=1 (set wins).
REQ-037 Empty stack, push+pop with 0xA5 -> count=1, top_data=0xA5, underflow=0; then clear with push=1 -> count=0, no write.
REQ-038 count=3, overflow=1, assert rst with push=1 -> next cycle count=0, overflow=0, empty=1, top_data=0x00.
